// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and opcode classifiers for the HI/LO
// multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2,
        ST_MUL  = 2'd3
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage interface between the decoder/pipeline (master) and the HI/LO
// multiply/divide sequencer (slave).
interface hilo_muldiv_ctrl_if #(parameter int DW = 32);
    logic          op_valid;
    logic [2:0]    op_code;
    logic [DW-1:0] src_a;
    logic [DW-1:0] src_b;
    logic          flush;
    logic          stall;
    logic          busy;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;

    modport master (
        output op_valid, op_code, src_a, src_b, flush,
        input  stall, busy, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, flush,
        output stall, busy, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl_div_radix2.sv
// Restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// with sign correction applied to the final quotient/remainder.
module hilo_muldiv_ctrl_div_radix2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    input  logic          last,
    input  logic          sign,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder
);

    function automatic logic [DW-1:0] neg_if(input logic sel, input logic [DW-1:0] v);
        return sel ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [DW-1:0] rem_r;
    logic [DW-1:0] quo_r;
    logic [DW-1:0] dvs_r;
    logic          neg_q_r;
    logic          neg_r_r;
    logic          run_r;

    logic [DW:0]   shifted_s;
    logic [DW:0]   diff_s;
    logic          qbit_s;
    logic [DW-1:0] rem_nx_s;
    logic [DW-1:0] quo_nx_s;

    // One restoring step; the remainder always fits DW bits since it stays below the divisor
    always_comb begin
        shifted_s = {rem_r, quo_r[DW-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
        qbit_s    = ~diff_s[DW];
        if (qbit_s) begin
            rem_nx_s = diff_s[DW-1:0];
        end else begin
            rem_nx_s = shifted_s[DW-1:0];
        end
        quo_nx_s  = {quo_r[DW-2:0], qbit_s};
    end

    assign done      = run_r & last;
    assign quotient  = neg_if(neg_q_r, quo_nx_s);
    assign remainder = neg_if(neg_r_r, rem_nx_s);

    // Operand latch and iteration registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_r   <= {DW{1'b0}};
            quo_r   <= {DW{1'b0}};
            dvs_r   <= {DW{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            run_r   <= 1'b0;
        end else if (abort) begin
            rem_r   <= {DW{1'b0}};
            quo_r   <= {DW{1'b0}};
            dvs_r   <= {DW{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            run_r   <= 1'b0;
        end else if (start) begin
            rem_r   <= {DW{1'b0}};
            quo_r   <= neg_if(sign & a[DW-1], a);
            dvs_r   <= neg_if(sign & b[DW-1], b);
            neg_q_r <= sign & (a[DW-1] ^ b[DW-1]);
            neg_r_r <= sign & a[DW-1];
            run_r   <= 1'b1;
        end else if (run_r) begin
            rem_r   <= rem_nx_s;
            quo_r   <= quo_nx_s;
            run_r   <= ~last;
        end else begin
            run_r   <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer for the EX stage.
// Optional macro MULT_2CYCLE_EN registers multiply operands and adds a MUL state.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    hilo_muldiv_ctrl_if.slave  md
);

`ifdef MULT_2CYCLE_EN
    localparam logic MUL_STALL = 1'b1;
`else
    localparam logic MUL_STALL = 1'b0;
`endif

    md_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [DW-1:0]    hi_r;
    logic [DW-1:0]    lo_r;
    logic             busy_r;

    logic             stall_s;
    logic             issue_s;
    logic             div_start_s;
    logic             div_last_s;
    logic             div_done_s;
    logic [DW-1:0]    div_q_s;
    logic [DW-1:0]    div_r_s;
    logic             mul_signed_s;
    logic [2*DW-1:0]  ext_a_s;
    logic [2*DW-1:0]  ext_b_s;
    logic [2*DW-1:0]  prod_s;

    assign issue_s     = (state_r == ST_IDLE) & md.op_valid & ~md.flush;
    assign div_start_s = issue_s & is_div_op(md.op_code);
    assign div_last_s  = (cnt_r == CNT_W'(DW - 1));

    // Sign-extend operands to full product width so one multiplier serves both forms
    always_comb begin
        mul_signed_s = (md.op_code == MD_MULT);
        ext_a_s      = {{DW{mul_signed_s & md.src_a[DW-1]}}, md.src_a};
        ext_b_s      = {{DW{mul_signed_s & md.src_b[DW-1]}}, md.src_b};
    end

`ifdef MULT_2CYCLE_EN
    logic [2*DW-1:0] mul_a_r;
    logic [2*DW-1:0] mul_b_r;

    // Multiply operand capture in the issue cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mul_a_r <= {(2*DW){1'b0}};
            mul_b_r <= {(2*DW){1'b0}};
        end else if (issue_s && is_mul_op(md.op_code)) begin
            mul_a_r <= ext_a_s;
            mul_b_r <= ext_b_s;
        end else begin
            mul_a_r <= mul_a_r;
            mul_b_r <= mul_b_r;
        end
    end

    assign prod_s = mul_a_r * mul_b_r;
`else
    assign prod_s = ext_a_s * ext_b_s;
`endif

    // Pipeline hold; reset and flush always release it
    always_comb begin
        stall_s = 1'b0;
        if (!resetn || md.flush) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: stall_s = md.op_valid &
                                   (is_div_op(md.op_code) | (MUL_STALL & is_mul_op(md.op_code)));
                ST_DIV:  stall_s = 1'b1;
                default: stall_s = 1'b0;
            endcase
        end
    end

    hilo_muldiv_ctrl_div_radix2 #(.DW(DW)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start_s),
        .abort     (md.flush),
        .last      (div_last_s),
        .sign      (md.op_code == MD_DIV),
        .a         (md.src_a),
        .b         (md.src_b),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s)
    );

    // Sequencer FSM, iteration counter and architectural HI/LO
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {DW{1'b0}};
            lo_r    <= {DW{1'b0}};
            busy_r  <= 1'b0;
        end else if (md.flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (md.op_valid) begin
                        case (md.op_code)
                            MD_MTHI: hi_r <= md.src_a;
                            MD_MTLO: lo_r <= md.src_a;
                            MD_MULT, MD_MULTU: begin
`ifdef MULT_2CYCLE_EN
                                state_r <= ST_MUL;
                                busy_r  <= 1'b1;
`else
                                {hi_r, lo_r} <= prod_s;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                state_r <= ST_DIV;
                                cnt_r   <= {CNT_W{1'b0}};
                                busy_r  <= 1'b1;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        hi_r    <= div_r_s;
                        lo_r    <= div_q_s;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                // The div instruction is still presented here; it is consumed, not re-issued
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
`ifdef MULT_2CYCLE_EN
                ST_MUL: begin
                    {hi_r, lo_r} <= prod_s;
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign md.stall = stall_s;
    assign md.busy  = busy_r;
    assign md.hi_o  = hi_r;
    assign md.lo_o  = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

`ifdef MULT_2CYCLE_EN
    localparam int MS = 1;
`else
    localparam int MS = 0;
`endif
    localparam int DS = 33;

    logic clk;
    logic resetn;
    int   n_tests;
    int   n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv_ctrl_if #(.DW(32)) bus ();

    hilo_muldiv_ctrl #(.DW(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .md     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one op the way the pipeline does: hold it while stall is high,
    // then drop it one cycle after stall goes low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls);
        int guard;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.src_a    = a;
        bus.src_b    = b;
        stalls = 0;
        guard  = 0;
        #1;
        while (bus.stall === 1'b1 && guard < 100) begin
            stalls++;
            guard++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_code  = MD_NOP;
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint      sa;
        longint      sb;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = {hi, lo};
        case (op)
            MD_MTHI:  res = {a, lo};
            MD_MTLO:  res = {hi, a};
            MD_MULT:  res = 64'(sa * sb);
            MD_MULTU: res = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 32'd0) begin
                    q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
                res = {r, q};
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                res = {r, q};
            end
            default: res = {hi, lo};
        endcase
        return res;
    endfunction

    initial begin
        int st;
        logic [63:0] exp;
        logic [2:0]  ops[6];
        n_tests = 0;
        n_fail  = 0;
        ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO};

        vecs[0]  = '{MD_MTHI,  32'h0000_1234, 32'h0,          32'h0000_1234, 32'h0000_0000, 0};
        vecs[1]  = '{MD_MTLO,  32'h0000_5678, 32'h0,          32'h0000_1234, 32'h0000_5678, 0};
        vecs[2]  = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MS};
        vecs[3]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, MS};
        vecs[4]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DS};
        vecs[5]  = '{MD_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, DS};
        vecs[6]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DS};
        vecs[7]  = '{MD_NOP,   32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[8]  = '{3'd7,     32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[9]  = '{MD_DIV,   32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, DS};
        vecs[10] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001, DS};
        vecs[11] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, DS};

        bus.op_valid = 1'b0;
        bus.op_code  = MD_NOP;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        bus.flush    = 1'b0;
        resetn       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_hi",    bus.hi_o, 32'd0);
        chk("reset_lo",    bus.lo_o, 32'd0);
        chk("reset_busy",  {31'd0, bus.busy},  32'd0);
        chk("reset_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, st);
            chk($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].stalls));
            chk($sformatf("vec%0d_hi", i), bus.hi_o, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), bus.lo_o, vecs[i].lo);
            chk($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd0);
        end
        m_hi = vecs[11].hi;
        m_lo = vecs[11].lo;

        // Back-to-back MTHI / MTLO on consecutive cycles
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = MD_MTHI; bus.src_a = 32'h0000_AAAA;
        #1 chk("b2b_stall_mthi", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.op_code = MD_MTLO; bus.src_a = 32'h0000_BBBB;
        #1 chk("b2b_stall_mtlo", {31'd0, bus.stall}, 32'd0);
        chk("b2b_hi_early", bus.hi_o, 32'h0000_AAAA);
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op_code = MD_NOP;
        #1;
        chk("b2b_hi", bus.hi_o, 32'h0000_AAAA);
        chk("b2b_lo", bus.lo_o, 32'h0000_BBBB);
        m_hi = 32'h0000_AAAA;
        m_lo = 32'h0000_BBBB;

        // Flush in the issue cycle wins over op_valid
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = MD_DIV; bus.src_a = 32'd9; bus.src_b = 32'd2;
        bus.flush = 1'b1;
        #1 chk("flush_issue_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.op_code = MD_MTHI; bus.src_a = 32'h0BAD_0BAD;
        #1 chk("flush_mthi_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op_code = MD_NOP;
        #1;
        chk("flush_issue_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_issue_hi", bus.hi_o, m_hi);
        chk("flush_issue_lo", bus.lo_o, m_lo);

        // Flush in division iteration 10
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = MD_DIV; bus.src_a = 32'd1000; bus.src_b = 32'd3;
        repeat (10) @(negedge clk);
        #1 chk("div_it10_stall_before", {31'd0, bus.stall}, 32'd1);
        bus.flush = 1'b1;
        #1 chk("div_flush_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op_code = MD_NOP;
        #1;
        chk("div_flush_stall_next", {31'd0, bus.stall}, 32'd0);
        chk("div_flush_busy", {31'd0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);
        #1;
        chk("div_flush_hi", bus.hi_o, m_hi);
        chk("div_flush_lo", bus.lo_o, m_lo);
        chk("div_flush_busy_late", {31'd0, bus.busy}, 32'd0);

        // Reset asserted mid-division
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = MD_DIVU; bus.src_a = 32'd77; bus.src_b = 32'd5;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid_hi",    bus.hi_o, 32'd0);
        chk("rst_mid_lo",    bus.lo_o, 32'd0);
        chk("rst_mid_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_mid_busy",  {31'd0, bus.busy},  32'd0);
        @(negedge clk);
        bus.op_valid = 1'b0; bus.op_code = MD_NOP;
        resetn = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op(MD_DIVU, 32'd77, 32'd5, st);
        chk("post_rst_stalls", 32'(st), 32'(DS));
        chk("post_rst_hi", bus.hi_o, 32'd2);
        chk("post_rst_lo", bus.lo_o, 32'd15);
        m_hi = 32'd2;
        m_lo = 32'd15;

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          exp_st;
            op = ops[$urandom_range(0, 5)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 16);
                2: b = -$urandom_range(1, 16);
                3: a = 32'h8000_0000;
                default: a = a;
            endcase
            exp    = model(op, a, b, m_hi, m_lo);
            exp_st = is_div_op(op) ? DS : (is_mul_op(op) ? MS : 0);
            run_op(op, a, b, st);
            chk($sformatf("rnd%0d_op%0d_stalls", i, op), 32'(st), 32'(exp_st));
            chk($sformatf("rnd%0d_op%0d_a%h_b%h_hi", i, op, a, b), bus.hi_o, exp[63:32]);
            chk($sformatf("rnd%0d_op%0d_a%h_b%h_lo", i, op, a, b), bus.lo_o, exp[31:0]);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
